// File: rtl/flag_branch_unit.sv
// Architectural {Z,V,N} flag register with per-opcode write masks, branch
// condition evaluation and flag-hazard stall. Optional macro: FLAG_BYPASS_EN.
module flag_branch_unit #(
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic       ex_flush,
  input  logic       stall,
  input  logic [3:0] ex_opcode,
  input  logic       Z_set,
  input  logic       V_set,
  input  logic       N_set,
  input  logic       id_branch,
  input  logic [2:0] id_ccc,
  output logic [2:0] flags_out,
  output logic       flag_wr,
  output logic       branch_taken,
  output logic       hazard_stall
);

  localparam logic [2:0] MASK_ZVN  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b100;
  localparam logic [2:0] MASK_NONE = 3'b000;

  logic [2:0] flags_q;
  logic [2:0] flags_d;
  logic [2:0] wr_mask;
  logic [2:0] set_vec;
  logic [2:0] eff;
  logic       wr_ok;
  logic       dep;
  logic       cond_met;

  // Bit order everywhere is {Z, V, N}.
  always_comb begin
    wr_mask = MASK_NONE;
    case (ex_opcode)
      4'h0, 4'h1:             wr_mask = MASK_ZVN;
      4'h2, 4'h4, 4'h5, 4'h6: wr_mask = MASK_Z;
      default:                wr_mask = MASK_NONE;
    endcase
  end

  assign set_vec = {Z_set, V_set, N_set};
  assign wr_ok   = ex_valid & ~ex_flush & ~stall;
  assign flag_wr = wr_ok & (wr_mask != MASK_NONE);

  always_comb begin
    flags_d = flags_q;
    if (wr_ok) begin
      flags_d = (wr_mask & set_vec) | (~wr_mask & flags_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= FLAG_RST;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_out = flags_q;

  // A flag-setting EX instruction still counts even while stalled, since it
  // will write once the stall drops.
  assign dep = id_branch & (id_ccc != 3'b111) & ex_valid & ~ex_flush &
               (wr_mask != MASK_NONE);

`ifdef FLAG_BYPASS_EN
  assign eff          = flags_d;
  assign hazard_stall = dep & stall;
`else
  assign eff          = flags_q;
  assign hazard_stall = dep;
`endif

  always_comb begin
    cond_met = 1'b0;
    case (id_ccc)
      3'b000:  cond_met = ~eff[2];
      3'b001:  cond_met = eff[2];
      3'b010:  cond_met = ~eff[2] & ~eff[0];
      3'b011:  cond_met = eff[0];
      3'b100:  cond_met = eff[2] | (~eff[2] & ~eff[0]);
      3'b101:  cond_met = eff[0] | eff[2];
      3'b110:  cond_met = eff[1];
      default: cond_met = 1'b1;
    endcase
  end

  assign branch_taken = id_branch & cond_met & ~hazard_stall;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: vector table, hand-written corner
// sequences and randomized traffic against a behavioural flag model.
module tb_flag_branch_unit;

  logic       clk;
  logic       rst;
  logic       ex_valid;
  logic       ex_flush;
  logic       stall;
  logic [3:0] ex_opcode;
  logic       Z_set;
  logic       V_set;
  logic       N_set;
  logic       id_branch;
  logic [2:0] id_ccc;
  logic [2:0] flags_out;
  logic       flag_wr;
  logic       branch_taken;
  logic       hazard_stall;

  flag_branch_unit #(.FLAG_RST(3'b000)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .ex_opcode    (ex_opcode),
    .Z_set        (Z_set),
    .V_set        (V_set),
    .N_set        (N_set),
    .id_branch    (id_branch),
    .id_ccc       (id_ccc),
    .flags_out    (flags_out),
    .flag_wr      (flag_wr),
    .branch_taken (branch_taken),
    .hazard_stall (hazard_stall)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       f;
    logic       s;
    logic [3:0] op;
    logic [2:0] zvn;
    logic       br;
    logic [2:0] ccc;
    logic       e_wr;
    logic       e_hz;
    logic       e_bt;
    logic [2:0] e_flags;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic [2:0] m_flags;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic f, input logic s,
                              input logic [3:0] op, input logic [2:0] zvn,
                              input logic br, input logic [2:0] ccc,
                              input logic e_wr, input logic e_hz,
                              input logic e_bt, input logic [2:0] e_flags);
    vec_t r;
    r.v = v; r.f = f; r.s = s; r.op = op; r.zvn = zvn; r.br = br; r.ccc = ccc;
    r.e_wr = e_wr; r.e_hz = e_hz; r.e_bt = e_bt; r.e_flags = e_flags;
    return r;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic cond_holds(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (ccc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic vec_t model(input vec_t in, input logic [2:0] cur);
    vec_t r;
    logic writes_all, writes_z, ok, dep;
    logic [2:0] nxt, eff;
    r = in;
    writes_all = (in.op == 4'd0) || (in.op == 4'd1);
    writes_z   = writes_all || (in.op == 4'd2) || (in.op == 4'd4) ||
                 (in.op == 4'd5) || (in.op == 4'd6);
    ok  = in.v && !in.f && !in.s;
    nxt = cur;
    if (ok && writes_z)   nxt[2]   = in.zvn[2];
    if (ok && writes_all) nxt[1:0] = in.zvn[1:0];
    dep = in.br && (in.ccc != 3'd7) && in.v && !in.f && writes_z;
`ifdef FLAG_BYPASS_EN
    eff    = nxt;
    r.e_hz = dep && in.s;
`else
    eff    = cur;
    r.e_hz = dep;
`endif
    r.e_wr    = ok && writes_z;
    r.e_bt    = in.br && cond_holds(in.ccc, eff) && !r.e_hz;
    r.e_flags = nxt;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    ex_valid = 0; ex_flush = 0; stall = 0; ex_opcode = 4'h0;
    Z_set = 0; V_set = 0; N_set = 0; id_branch = 0; id_ccc = 3'b000;
  endtask

  // Inputs are driven just after posedge, outputs sampled on negedge,
  // registered flags checked 1 time unit after the following posedge.
  task automatic run_cycle(input vec_t t, input string tag);
    ex_valid = t.v; ex_flush = t.f; stall = t.s; ex_opcode = t.op;
    {Z_set, V_set, N_set} = t.zvn; id_branch = t.br; id_ccc = t.ccc;
    @(negedge clk);
    chk({tag, ".flag_wr"}, {2'b0, flag_wr}, {2'b0, t.e_wr});
    chk({tag, ".hazard_stall"}, {2'b0, hazard_stall}, {2'b0, t.e_hz});
    chk({tag, ".branch_taken"}, {2'b0, branch_taken}, {2'b0, t.e_bt});
    exp_q.push_back(t.e_flags);
    @(posedge clk);
    #1;
    chk({tag, ".flags_out"}, flags_out, exp_q.pop_front());
    m_flags = t.e_flags;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1;
    #1;
    chk("reset.flags_out", flags_out, 3'b000);
    chk("reset.flag_wr", {2'b0, flag_wr}, 3'b000);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    m_flags = 3'b000;
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1;
    idle_inputs();
    m_flags = 3'b000;
    #1;
    chk("por.flags_out", flags_out, 3'b000);
    chk("por.hazard_stall", {2'b0, hazard_stall}, 3'b000);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    //            v f s op    zvn   br ccc   wr hz bt flags
    tbl[0]  = mk(1,0,0,4'h0,3'b010,0,3'd0, 1,0,0,3'b010); // ADD overflow
    tbl[1]  = mk(0,0,0,4'h0,3'b000,1,3'd6, 0,0,1,3'b010); // OV taken
    tbl[2]  = mk(1,0,0,4'h2,3'b100,0,3'd0, 1,0,0,3'b110); // XOR Z only
    tbl[3]  = mk(0,0,0,4'h0,3'b000,1,3'd1, 0,0,1,3'b110); // EQ
    tbl[4]  = mk(1,0,0,4'h7,3'b001,0,3'd0, 0,0,0,3'b110); // PADDSB no write
    tbl[5]  = mk(1,0,1,4'h1,3'b001,0,3'd0, 0,0,0,3'b110); // stalled SUB
    tbl[6]  = mk(1,1,0,4'h1,3'b001,0,3'd0, 0,0,0,3'b110); // flushed SUB
    tbl[7]  = mk(1,0,0,4'h1,3'b001,0,3'd0, 1,0,0,3'b001); // SUB
    tbl[8]  = mk(0,0,0,4'h0,3'b000,1,3'd3, 0,0,1,3'b001); // LT
    tbl[9]  = mk(0,0,0,4'h0,3'b000,1,3'd2, 0,0,0,3'b001); // GT not taken
    tbl[10] = mk(0,0,0,4'h0,3'b000,1,3'd5, 0,0,1,3'b001); // LE
    tbl[11] = mk(1,0,0,4'h5,3'b111,1,3'd7, 1,0,1,3'b101); // SRA + always
    tbl[12] = mk(0,0,0,4'h0,3'b000,1,3'd0, 0,0,0,3'b101); // NE not taken
    tbl[13] = mk(0,0,0,4'h0,3'b000,1,3'd4, 0,0,1,3'b101); // GE
    tbl[14] = mk(1,0,0,4'h8,3'b000,0,3'd0, 0,0,0,3'b101); // LW no write
    for (int i = 0; i < 15; i++) run_cycle(tbl[i], $sformatf("tbl%0d", i));

    // Z-only write holds V and N; PADDSB leaves flags alone
    do_reset();
    run_cycle(mk(1,0,0,4'h0,3'b011,0,3'd0, 1,0,0,3'b011), "zonly.add");
    run_cycle(mk(1,0,0,4'h2,3'b100,0,3'd0, 1,0,0,3'b111), "zonly.xor");
    run_cycle(mk(1,0,0,4'h7,3'b100,0,3'd0, 0,0,0,3'b111), "zonly.paddsb");

    // stall held three cycles then one write; flush blocks write
    for (int i = 0; i < 3; i++)
      run_cycle(mk(1,0,1,4'h1,3'b100,0,3'd0, 0,0,0,3'b111), $sformatf("stall%0d", i));
    run_cycle(mk(1,0,0,4'h1,3'b100,0,3'd0, 1,0,0,3'b100), "stall.release");
    run_cycle(mk(1,1,0,4'h1,3'b011,0,3'd0, 0,0,0,3'b100), "flush");

    // branch against flags still in EX
    run_cycle(mk(1,0,0,4'h1,3'b000,0,3'd0, 1,0,0,3'b000), "br.clear");
`ifdef FLAG_BYPASS_EN
    run_cycle(mk(1,0,0,4'h1,3'b100,1,3'd1, 1,0,1,3'b100), "br.eq_dep");
`else
    run_cycle(mk(1,0,0,4'h1,3'b100,1,3'd1, 1,1,0,3'b100), "br.eq_dep");
`endif
    run_cycle(mk(0,0,0,4'h0,3'b000,1,3'd1, 0,0,1,3'b100), "br.eq_after");
    run_cycle(mk(1,0,0,4'h1,3'b000,1,3'd7, 1,0,1,3'b000), "br.always");
`ifdef FLAG_BYPASS_EN
    run_cycle(mk(1,0,0,4'h0,3'b001,1,3'd2, 1,0,0,3'b001), "br.gt_dep");
`else
    run_cycle(mk(1,0,0,4'h0,3'b001,1,3'd2, 1,1,0,3'b001), "br.gt_dep");
`endif
    run_cycle(mk(0,0,0,4'h0,3'b000,1,3'd2, 0,0,0,3'b001), "br.gt_after");

    // reset mid-stream with flags=111 and a pending write discarded
    run_cycle(mk(1,0,0,4'h0,3'b111,0,3'd0, 1,0,0,3'b111), "rst.prep");
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #1;
    chk("midrst.flags_out", flags_out, 3'b000);
    chk("midrst.flag_wr", {2'b0, flag_wr}, 3'b000);
    ex_valid = 1; ex_opcode = 4'h0; {Z_set, V_set, N_set} = 3'b111;
    @(posedge clk);
    #1;
    chk("midrst.pending", flags_out, 3'b000);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    m_flags = 3'b000;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      vec_t r;
      r.v   = ($urandom_range(0, 3) != 0);
      r.f   = ($urandom_range(0, 7) == 0);
      r.s   = ($urandom_range(0, 5) == 0);
      r.op  = 4'($urandom_range(0, 15));
      r.zvn = 3'($urandom_range(0, 7));
      r.br  = ($urandom_range(0, 1) == 1);
      r.ccc = 3'($urandom_range(0, 7));
      r = model(r, m_flags);
      run_cycle(r, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the EX-stage ALU and consumes its Z_set/V_set/N_set outputs.
- Holds the architectural flag register {Z,V,N} and applies per-opcode write rules.
- Evaluates the 3-bit branch condition for the B/BR instruction in ID and drives branch_taken.
- Requests a pipeline stall when a branch in ID depends on flags still being produced in EX.

Parameters:
- FLAG_RST, 3'b000, reset value of {Z,V,N}

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ex_valid  input  1  EX stage holds a real instruction (not a bubble)
- ex_flush  input  1  EX instruction is squashed; no flag write this cycle
- stall  input  1  global pipeline stall; hold flag register
- ex_opcode  input  4  opcode of the instruction in EX
- Z_set  input  1  ALU zero indication
- V_set  input  1  ALU overflow indication
- N_set  input  1  ALU negative indication
- id_branch  input  1  ID stage holds B or BR
- id_ccc  input  3  branch condition code from ID
- flags_out  output  3  registered {Z,V,N}
- flag_wr  output  1  flag register written at the next clock edge (combinational)
- branch_taken  output  1  ID branch condition satisfied (combinational)
- hazard_stall  output  1  ID must hold one cycle for flags (combinational)

Behaviour:
- Reset: rst=1 asynchronously forces flags_out=FLAG_RST. All combinational outputs derive from the reset value: flag_wr=0 and hazard_stall=0 while ex_valid=0. Reset asserted mid-operation discards any pending write.
- Write qualify: wr_ok = ex_valid & ~ex_flush & ~stall.
- Write masks by ex_opcode:
  - 4'h0 ADD, 4'h1 SUB: write Z, V and N.
  - 4'h2 XOR, 4'h4 SLL, 4'h5 SRA, 4'h6 ROR: write Z only; V and N hold.
  - All other opcodes, including RED, PADDSB, LW/SW, LLB/LHB and control: no write.
- flag_wr = wr_ok & (mask != 0).
- Update: at posedge clk, each masked bit takes its *_set input; unmasked bits hold. Latency is one cycle from ALU result to flags_out.
- Simultaneous stall and ex_valid: stall wins; no write. A held instruction writes once, on the cycle stall drops.
- ex_flush with a flag-setting opcode: no write.
- Effective flags: eff = {Z,V,N} seen by the condition evaluator (see Optional Feature).
- Condition codes, with Z,V,N taken from eff:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always: 1
- branch_taken = id_branch & cond(id_ccc, eff) & ~hazard_stall. It is 0 when id_branch=0.
- The ccc=111 branch never depends on flags, so hazard_stall=0 for it.
- Hazard: dep = id_branch & (id_ccc != 3'b111) & ex_valid & ~ex_flush & (mask != 0).
- Partial masks (Z-only writers) count as a dependency for all ccc values except 111.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - eff = the next-state flags, i.e. masked *_set merged with held bits whenever wr_ok.
  - hazard_stall = dep & stall, so it only reflects an already-stalled pipe.
  - A branch immediately after an ADD resolves in the same cycle with no bubble.
- Undefined:
  - eff = flags_out.
  - hazard_stall = dep. ID holds one cycle until the writer retires, then the branch evaluates against the updated flags_out.

Test Plan:
- Reset: rst=1 mid-stream with flags=3'b111 -> flags_out=3'b000 immediately, no clock required. flag_wr=0.
- ADD overflow: ex_opcode=0, Z_set=0, V_set=1, N_set=0, ex_valid=1 -> next cycle flags_out=3'b010. flag_wr=1 in the prior cycle.
- Z-only write: with flags=3'b011, XOR with Z_set=1, V_set=0, N_set=0 -> flags_out=3'b111 (V,N held). Same stimulus with ex_opcode=4'h7 PADDSB -> flags unchanged.
- Stall/flush: SUB with Z_set=1 under stall=1 for 3 cycles -> no change. Release stall -> one write. ex_flush=1 -> no write.
- Branch, no bypass: SUB in EX producing Z=1, id_branch=1, id_ccc=001 -> hazard_stall=1, branch_taken=0. Next cycle branch_taken=1. With id_ccc=111 -> hazard_stall=0, branch_taken=1 immediately.
- Branch, FLAG_BYPASS_EN: same stimulus -> hazard_stall=0 and branch_taken=1 in the same cycle. ccc=010 with N_set=1 -> branch_taken=0.
